ext_bus_responder: RTL
======================

Name: ext_bus_responder

Overview:
- Responder on the 2A03 external CPU bus: the far end of the APU address/data/R/W/M2 pads.
- Samples M2, R/W, A[15:0] and D[7:0]. Implements an MMC1-style 5-bit serial register loader for writes to $8000-$FFFF.
- Optionally drives register read-back onto the data bus for reads in $6000-$7FFF.
- Used as the cartridge-side model in full-system 2A03 simulation and as a bus-protocol checker target.

Parameters:
- READBACK_EN, 1, enables data-bus drive for read-back reads in $6000-$7FFF.
- CTRL_RESET, 5'h0C, value loaded into Ctrl at reset and on a bit-7 reset write.

Ports:
- CLK  input  1  master clock. M2Pad, RWPad, APads and DPads_in are synchronous to it, since M2 is divided from it.
- RES  input  1  reset, asynchronous, active-high.
- M2Pad  input  1  M2 from the CPU side.
- RWPad  input  1  R/W from the CPU side, 1 = read.
- APads  input  16  address bus.
- DPads_in  input  8  data bus value seen at the pads.
- DPads_out  output  8  read-back data.
- DPads_oe  output  1  data bus drive enable.
- Ctrl  output  5  control register.
- Chr0  output  5  CHR bank 0.
- Chr1  output  5  CHR bank 1.
- Prg  output  5  PRG bank.
- LoadDone  output  1  one-CLK pulse when a 5-bit load commits.

Behaviour:
- Reset (async, RES=1) forces these values:
  - Ctrl=CTRL_RESET; Chr0=Chr1=Prg=0.
  - shift register sr=5'b10000 (marker-bit scheme); prev_write=0.
  - LoadDone=0, DPads_oe=0, DPads_out=0.
  - Internal m2_q=0, cycle latches cleared.
- Bus cycle tracking:
  - m2_q registers M2Pad every CLK.
  - Rise = M2Pad & ~m2_q. Fall = ~M2Pad & m2_q.
  - While M2Pad=1, every CLK captures a_lat<=APads, d_lat<=DPads_in, rw_lat<=RWPad, so the last value before the fall wins.
  - At a fall, the captured cycle is committed, with no further latency.
- Serial write: a committed cycle with rw_lat=0 and a_lat[15]=1.
  - If prev_write=1 (the previous committed cycle was also a serial write), the cycle is ignored. This is the consecutive-cycle rule, covering RMW double writes.
  - Else if d_lat[7]=1: sr<=5'b10000 and Ctrl<=Ctrl|CTRL_RESET. No other register changes.
  - Else: nsr={d_lat[0],sr[4:1]}.
    - If sr[0]=1 (fifth bit), target <= nsr and sr<=5'b10000. Target select: a_lat[14:13]=00 Ctrl, 01 Chr0, 10 Chr1, 11 Prg. LoadDone=1 for the CLK after the fall.
    - Else sr<=nsr.
  - Only the address of the fifth write selects the target.
- prev_write update at every fall:
  - Set to 1 for any serial write, ignored ones included.
  - Set to 0 for any other committed cycle (reads, or writes below $8000).
- Read-back, only when READBACK_EN=1:
  - Condition: M2Pad=1, RWPad=1, APads[15:13]=3'b011.
  - DPads_oe is combinational from the pads. DPads_out={3'b000, reg[APads[1:0]]} with 0=Ctrl, 1=Chr0, 2=Chr1, 3=Prg.
  - Otherwise DPads_oe=0 and DPads_out=0.
  - When READBACK_EN=0, DPads_oe is tied 0.
- Boundary conditions:
  - M2Pad high at reset release: no fall is seen until m2_q has registered a 1, so no spurious commit occurs.
  - RES asserted mid-load: all state returns to reset values, and a partial sr is discarded.
  - Writes to $4020-$7FFF and all reads commit no register change but clear prev_write.
  - A register value written while M2 is high is visible on read-back from the next cycle onward.

Decomposition:
- Shared package holds:
  - address-window constants (SERIAL_MASK $8000, READBACK_BASE $6000);
  - SR_EMPTY=5'b10000;
  - register index encoding (REG_CTRL..REG_PRG).
- One sub-module, bus_cycle_tracker: M2 edge detect, cycle latches, commit pulse, prev_write flag.
- The serial loader and read-back mux stay in the top.

Test Plan:
- Reset, then five non-consecutive writes (idle read cycles between) to $E000 with D bit0 = 1,0,1,1,0 -> Prg=5'b01101, one LoadDone pulse, sr back to 10000.
- Reset, then write $80 to $8000 after two bits loaded -> sr=10000, Ctrl=5'h0C. The next five writes to $A000 with bits 1,1,1,1,1 -> Chr0=5'h1F.
- Two back-to-back write cycles to $8000 (RMW pattern: first D=$01, second D=$00) -> only the first bit is shifted (sr=5'b11000); the second is ignored.
- After loading Chr1=5'h15, read $6002 -> DPads_oe=1 only while M2 high, DPads_out=$15. Read $5FFF -> DPads_oe=0.
- Assert RES for 1 CLK after three serial bits, then five writes to $C000 with bits 0,0,0,0,1 -> Chr1=5'h10 and the earlier bits are lost.
- With READBACK_EN=0, read $6000 -> DPads_oe stays 0 throughout.

Source files
------------

// File: rtl/ext_bus_responder_pkg.sv
// rtl/ext_bus_responder_pkg.sv - shared constants and helpers for the cartridge-side bus responder
package ext_bus_responder_pkg;

  localparam logic [15:0] SERIAL_MASK   = 16'h8000;
  localparam logic [15:0] READBACK_BASE = 16'h6000;
  localparam logic [4:0]  SR_EMPTY      = 5'b10000;

  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_CHR0 = 2'd1,
    REG_CHR1 = 2'd2,
    REG_PRG  = 2'd3
  } reg_idx_e;

  function automatic logic is_serial(input logic [15:0] addr);
    return (addr & SERIAL_MASK) != 16'h0000;
  endfunction

  // Read-back window is the 8 KiB block $6000-$7FFF.
  function automatic logic in_readback(input logic [15:0] addr);
    return addr[15:13] == READBACK_BASE[15:13];
  endfunction

endpackage

// File: rtl/ext_bus_responder_bus_cycle_tracker.sv
// rtl/ext_bus_responder_bus_cycle_tracker.sv - M2 edge detect, cycle latches, commit pulse, prev_write flag
module bus_cycle_tracker (
  input  logic        clk,
  input  logic        rst,
  input  logic        m2,
  input  logic        rw,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  output logic        commit,
  output logic [15:0] a_lat,
  output logic [7:0]  d_lat,
  output logic        rw_lat,
  output logic        prev_write
);
  import ext_bus_responder_pkg::*;

  logic m2_q;

  // m2_q clears on reset, so M2 held high across release cannot produce a fall.
  assign commit = ~m2 & m2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m2_q       <= 1'b0;
      a_lat      <= 16'h0000;
      d_lat      <= 8'h00;
      rw_lat     <= 1'b0;
      prev_write <= 1'b0;
    end else begin
      m2_q <= m2;
      if (m2) begin
        a_lat  <= addr;
        d_lat  <= data;
        rw_lat <= rw;
      end
      if (commit) begin
        prev_write <= ~rw_lat & is_serial(a_lat);
      end
    end
  end

endmodule

// File: rtl/ext_bus_responder.sv
// rtl/ext_bus_responder.sv - MMC1-style serial register loader with optional $6000-$7FFF read-back
module ext_bus_responder #(
  parameter bit         READBACK_EN = 1'b1,
  parameter logic [4:0] CTRL_RESET  = 5'h0C
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        M2Pad,
  input  logic        RWPad,
  input  logic [15:0] APads,
  input  logic [7:0]  DPads_in,
  output logic [7:0]  DPads_out,
  output logic        DPads_oe,
  output logic [4:0]  Ctrl,
  output logic [4:0]  Chr0,
  output logic [4:0]  Chr1,
  output logic [4:0]  Prg,
  output logic        LoadDone
);
  import ext_bus_responder_pkg::*;

  logic        commit;
  logic [15:0] a_lat;
  logic [7:0]  d_lat;
  logic        rw_lat;
  logic        prev_write;
  logic [4:0]  sr;
  logic [4:0]  nsr;
  logic        serial_wr;
  logic [4:0]  rb_sel;
  logic        unused_bits;

  bus_cycle_tracker u_tracker (
    .clk        (CLK),
    .rst        (RES),
    .m2         (M2Pad),
    .rw         (RWPad),
    .addr       (APads),
    .data       (DPads_in),
    .commit     (commit),
    .a_lat      (a_lat),
    .d_lat      (d_lat),
    .rw_lat     (rw_lat),
    .prev_write (prev_write)
  );

  assign serial_wr   = commit & ~rw_lat & is_serial(a_lat) & ~prev_write;
  assign nsr         = {d_lat[0], sr[4:1]};
  assign unused_bits = ^{a_lat[12:0], d_lat[6:1], APads[12:2]};

  // The marker bit reaching sr[0] means four bits are already held; this write is the fifth.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      Ctrl     <= CTRL_RESET;
      Chr0     <= 5'h00;
      Chr1     <= 5'h00;
      Prg      <= 5'h00;
      sr       <= SR_EMPTY;
      LoadDone <= 1'b0;
    end else begin
      LoadDone <= 1'b0;
      if (serial_wr) begin
        if (d_lat[7]) begin
          sr   <= SR_EMPTY;
          Ctrl <= Ctrl | CTRL_RESET;
        end else if (sr[0]) begin
          sr       <= SR_EMPTY;
          LoadDone <= 1'b1;
          case (a_lat[14:13])
            REG_CTRL: Ctrl <= nsr;
            REG_CHR0: Chr0 <= nsr;
            REG_CHR1: Chr1 <= nsr;
            REG_PRG:  Prg  <= nsr;
            default:  Ctrl <= nsr;
          endcase
        end else begin
          sr <= nsr;
        end
      end
    end
  end

  always_comb begin
    rb_sel = Ctrl;
    case (APads[1:0])
      REG_CTRL: rb_sel = Ctrl;
      REG_CHR0: rb_sel = Chr0;
      REG_CHR1: rb_sel = Chr1;
      REG_PRG:  rb_sel = Prg;
      default:  rb_sel = Ctrl;
    endcase
  end

  generate
    if (READBACK_EN) begin : g_readback
      assign DPads_oe  = M2Pad & RWPad & in_readback(APads);
      assign DPads_out = DPads_oe ? {3'b000, rb_sel} : 8'h00;
    end else begin : g_no_readback
      assign DPads_oe  = 1'b0;
      assign DPads_out = 8'h00;
    end
  endgenerate

endmodule
